// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of a single-port synchronous-read ROM: fixed priority
// to the video fetch (port 0), with a starvation guard that forces a port-1 slot.
module rom_port_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 12,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_miss,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  // A zero-width counter is not legal, so keep one bit when the guard is disabled.
  localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int DEPTH = ROM_LAT + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              p0_miss_q, p0_miss_d;
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DEPTH-1:0]  port_q, port_d;
  logic              force_slot;

  always_comb begin
    force_slot = (STARVE_MAX != 0) && (starve_q == CNT_MAX) && p1_req;
    p0_gnt     = 1'b0;
    p1_gnt     = 1'b0;
    if (!rst) begin
      if (force_slot) begin
        p1_gnt = 1'b1;
      end else if (p0_req) begin
        p0_gnt = 1'b1;
      end else if (p1_req) begin
        p1_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    rom_addr_d = rom_addr_q;
    if (p0_gnt) begin
      rom_addr_d = p0_addr;
    end else if (p1_gnt) begin
      rom_addr_d = p1_addr;
    end

    // An abandoned port-1 request also clears the count.
    starve_d = starve_q;
    if (p1_gnt || !p1_req) begin
      starve_d = '0;
    end else if (starve_q != CNT_MAX) begin
      starve_d = starve_q + CNT_W'(1);
    end

    p0_miss_d = p0_req && !p0_gnt;
    vld_d     = {vld_q[DEPTH-2:0], p0_gnt | p1_gnt};
    port_d    = {port_q[DEPTH-2:0], p1_gnt};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      starve_q   <= '0;
      p0_miss_q  <= 1'b0;
      vld_q      <= '0;
      port_q     <= '0;
    end else begin
      rom_addr_q <= rom_addr_d;
      starve_q   <= starve_d;
      p0_miss_q  <= p0_miss_d;
      vld_q      <= vld_d;
      port_q     <= port_d;
    end
  end

  // Stage ROM_LAT lines up with the ROM output for the address granted ROM_LAT+1 cycles ago.
  assign p0_rvalid = vld_q[ROM_LAT] && !port_q[ROM_LAT];
  assign p1_rvalid = vld_q[ROM_LAT] && port_q[ROM_LAT];
  assign p0_rdata  = rom_data;
  assign p1_rdata  = rom_data;
  assign p0_miss   = p0_miss_q;
  assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: two instances (LAT1/STARVE8 and LAT3/no guard) share
// stimulus and are checked every cycle against a cycle-indexed expectation model.
module tb_rom_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0;
  logic        p1_req = 1'b0;
  logic [19:0] p0_addr = '0;
  logic [19:0] p1_addr = '0;

  logic [1:0]       p0_gnt_w, p1_gnt_w, p0_rv_w, p1_rv_w, p0_miss_w;
  logic [1:0][11:0] p0_rd_w, p1_rd_w;
  logic [1:0][19:0] rom_addr_w;
  logic [11:0]      rom_a_q;
  logic [11:0]      rom_b_q [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [19:0] a);
    return a[11:0] ^ a[19:8] ^ 12'h5A3;
  endfunction

  // Behavioural ROMs: latency 1 and latency 3 from the registered address.
  always @(posedge clk) begin
    rom_a_q    <= rom_fn(rom_addr_w[0]);
    rom_b_q[0] <= rom_fn(rom_addr_w[1]);
    rom_b_q[1] <= rom_b_q[0];
    rom_b_q[2] <= rom_b_q[1];
  end

  rom_port_arbiter #(.ADDR_W(20), .DATA_W(12), .ROM_LAT(1), .STARVE_MAX(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt_w[0]), .p0_rvalid(p0_rv_w[0]),
    .p0_rdata(p0_rd_w[0]), .p0_miss(p0_miss_w[0]),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt_w[0]), .p1_rvalid(p1_rv_w[0]),
    .p1_rdata(p1_rd_w[0]), .rom_addr(rom_addr_w[0]), .rom_data(rom_a_q)
  );

  rom_port_arbiter #(.ADDR_W(20), .DATA_W(12), .ROM_LAT(3), .STARVE_MAX(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_gnt(p0_gnt_w[1]), .p0_rvalid(p0_rv_w[1]),
    .p0_rdata(p0_rd_w[1]), .p0_miss(p0_miss_w[1]),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_gnt(p1_gnt_w[1]), .p1_rvalid(p1_rv_w[1]),
    .p1_rdata(p1_rd_w[1]), .rom_addr(rom_addr_w[1]), .rom_data(rom_b_q[2])
  );

  // Reference model state, per instance.
  int          m_cnt [2];
  logic [19:0] m_addr [2];
  bit          m_miss [2];
  bit          ev_v [2][64];
  bit          ev_p [2][64];
  logic [19:0] ev_a [2][64];
  int          g1_cnt [2];
  bit          last_g1 [2];
  int          cyc = 0;

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d cycle %0d observed=%h expected=%h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 0;
      m_addr[d] = '0;
      m_miss[d] = 1'b0;
      for (int s = 0; s < 64; s++) ev_v[d][s] = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_p0_gnt"}, d, p0_gnt_w[d], 0);
      check({tag, "_p1_gnt"}, d, p1_gnt_w[d], 0);
      check({tag, "_p0_rvalid"}, d, p0_rv_w[d], 0);
      check({tag, "_p1_rvalid"}, d, p1_rv_w[d], 0);
      check({tag, "_p0_miss"}, d, p0_miss_w[d], 0);
      check({tag, "_rom_addr"}, d, rom_addr_w[d], 0);
    end
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance to posedge+1.
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int          sm, lat, slot;
      bit          frc, g0, g1, ev, evp;
      logic [19:0] eva;
      sm   = (d == 0) ? 8 : 0;
      lat  = (d == 0) ? 1 : 3;
      frc  = (sm != 0) && (m_cnt[d] == sm) && p1_req;
      g1   = frc || (!p0_req && p1_req);
      g0   = p0_req && !frc;
      slot = cyc % 64;
      ev   = ev_v[d][slot];
      evp  = ev_p[d][slot];
      eva  = ev_a[d][slot];
      ev_v[d][slot] = 1'b0;

      check("p0_gnt", d, p0_gnt_w[d], g0);
      check("p1_gnt", d, p1_gnt_w[d], g1);
      check("p0_rvalid", d, p0_rv_w[d], ev && !evp);
      check("p1_rvalid", d, p1_rv_w[d], ev && evp);
      if (ev && !evp) check("p0_rdata", d, p0_rd_w[d], rom_fn(eva));
      if (ev && evp)  check("p1_rdata", d, p1_rd_w[d], rom_fn(eva));
      check("rom_addr", d, rom_addr_w[d], m_addr[d]);
      check("p0_miss", d, p0_miss_w[d], m_miss[d]);
      check("dual_rvalid", d, p0_rv_w[d] & p1_rv_w[d], 0);

      if (g0 || g1) begin
        m_addr[d] = g1 ? p1_addr : p0_addr;
        slot = (cyc + 1 + lat) % 64;
        ev_v[d][slot] = 1'b1;
        ev_p[d][slot] = g1;
        ev_a[d][slot] = m_addr[d];
      end
      m_miss[d] = p0_req && !g0;
      if (g1 || !p1_req) m_cnt[d] = 0;
      else if (m_cnt[d] < sm) m_cnt[d]++;
      last_g1[d] = g1;
      if (g1) g1_cnt[d]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] alt_a, alt_b;
    model_reset();

    // Power-on reset, with both requests up to show grants are masked.
    @(posedge clk);
    @(posedge clk);
    #1;
    p0_req = 1'b1;
    p1_req = 1'b1;
    #1;
    check_reset_outputs("por");
    p0_req = 1'b0;
    p1_req = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Port 0 stream 0x00100..0x00104.
    for (int i = 0; i < 5; i++) begin
      p0_req  = 1'b1;
      p0_addr = 20'h00100 + 20'(i);
      step();
    end
    p0_req = 1'b0;
    repeat (5) step();

    // Port 1 alone.
    p1_req  = 1'b1;
    p1_addr = 20'h0BEEF;
    step();
    p1_req = 1'b0;
    repeat (5) step();

    // Continuous contention: guarded instance grants port 1 every ninth cycle.
    g1_cnt[0] = 0;
    g1_cnt[1] = 0;
    p0_req  = 1'b1;
    p1_req  = 1'b1;
    p1_addr = 20'h0ABCD;
    for (int i = 0; i < 27; i++) begin
      p0_addr = 20'($urandom);
      step();
    end
    check("p1_grants_in_27", 0, g1_cnt[0], 3);
    check("p1_grants_in_27", 1, g1_cnt[1], 0);
    repeat (4) begin
      p0_addr = 20'($urandom);
      step();
    end

    // Port 0 drops: port 1 granted that cycle on both instances.
    p0_req = 1'b0;
    step();
    check("p1_granted_on_p0_drop_a", 0, p1_gnt_w[0] | last_g1[0], 1);

    // Interleave: p0 toggles, p1 alternates between two addresses on each grant.
    alt_a   = 20'h12345;
    alt_b   = 20'h6789A;
    p1_addr = alt_a;
    for (int i = 0; i < 12; i++) begin
      p0_req  = (i % 2 == 0);
      p0_addr = 20'($urandom);
      step();
      if (i % 2 == 1) p1_addr = (p1_addr == alt_a) ? alt_b : alt_a;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (5) step();

    // Randomised traffic; port 1 holds its request until the guarded instance serves it.
    for (int i = 0; i < 200; i++) begin
      p0_req  = ($urandom_range(0, 3) != 0);
      p0_addr = 20'($urandom);
      if (!p1_req) begin
        p1_req  = ($urandom_range(0, 2) == 0);
        p1_addr = 20'($urandom);
      end
      step();
      if (last_g1[0]) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (5) step();

    // Reset mid-stream with reads in flight.
    for (int i = 0; i < 3; i++) begin
      p0_req  = 1'b1;
      p0_addr = 20'h40000 + 20'(i);
      step();
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    p0_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
